seven_seg_scanner: RTL and testbench

Time-multiplexed driver for the 8-digit common-anode seven-segment display on the Nexys board. It consumes the calculator's ToDisplay, Flags and Status outputs and presents them on the display:
- ToDisplay as 4 hex digits on digits 3..0.
- Status as a hex digit on digit 7.
- Flags {N,Z,C,V} on the decimal points of digits 7..4.

Inputs are snapshotted once per full scan so the display never shows a torn value.

---
 rtl/seven_seg_pkg.sv | 12 +
 rtl/seven_seg_scanner_if.sv | 12 +
 rtl/hex_to_7seg.sv | 11 +
 rtl/seven_seg_scanner.sv | 80 ++++++++
 tb/tb_seven_seg_scanner.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants and active-low hex segment table for the display scanner
package seven_seg_pkg;
    localparam int N_DIGITS = 8;
    localparam logic [2:0] DIG_STATUS = 3'd7;
    localparam logic [2:0] DIG_VAL_MSB = 3'd3;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    // {g,f,e,d,c,b,a}, a zero bit lights the segment
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: calculator-side values in, display pins out
interface seven_seg_scanner_if;
    import seven_seg_pkg::*;
    logic [15:0] ToDisplay;
    logic [3:0] Flags;
    logic [2:0] Status;
    logic [N_DIGITS-1:0] AN;
    logic [6:0] SEG;
    logic DP;
    modport master(output ToDisplay, Flags, Status, input AN, SEG, DP);
    modport slave(input ToDisplay, Flags, Status, output AN, SEG, DP);
endinterface

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: nibble to active-low segment pattern, with forced blank
module hex_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);
    // table lookup unless the digit is suppressed
    always_comb seg = blank ? SEG_BLANK : HEX_SEG[nibble];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 8-digit driver with per-frame input snapshot
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int LZ_BLANK     = 0
) (
    input logic clk,
    input logic resetN,
    seven_seg_scanner_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] div_cnt;
    logic [2:0] dig;
    logic [15:0] snap_val;
    logic [3:0] snap_flags;
    logic [2:0] snap_stat;
    logic wrap;
    logic [3:0] lz_zero;
    logic lz_hit;
    logic digit_blank;
    logic dp_d;
    logic [3:0] nibble;
    logic [6:0] seg_d;

    // digit content selection; lz_zero[k] means nibbles k..3 are all zero (digit 0 never blanks)
    always_comb begin
        wrap = div_cnt == DIV_LAST;
        lz_zero[3] = snap_val[15:12] == 4'h0;
        lz_zero[2] = lz_zero[3] && snap_val[11:8] == 4'h0;
        lz_zero[1] = lz_zero[2] && snap_val[7:4] == 4'h0;
        lz_zero[0] = 1'b0;
        lz_hit = LZ_BLANK != 0 && !dig[2] && lz_zero[dig[1:0]];
        digit_blank = (dig > DIG_VAL_MSB && dig != DIG_STATUS) || lz_hit;
        nibble = dig == DIG_STATUS ? {1'b0, snap_stat} : snap_val[{dig[1:0], 2'b00} +: 4];
        dp_d = dig > DIG_VAL_MSB ? ~snap_flags[dig[1:0]] : 1'b1;
    end

    hex_to_7seg u_hex (
        .nibble(nibble),
        .blank (digit_blank),
        .seg   (seg_d)
    );

    // slot counter, digit index, and once-per-frame snapshot on the 7->0 wrap
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_cnt <= '0;
            dig <= '0;
            snap_val <= '0;
            snap_flags <= '0;
            snap_stat <= '0;
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + 1'b1;
            if (wrap) dig <= dig + 1'b1;
            if (wrap && dig == DIG_STATUS) begin
                snap_val <= bus.ToDisplay;
                snap_flags <= bus.Flags;
                snap_stat <= bus.Status;
            end
        end
    end

    // registered pins; anodes stay off during the start-of-slot blanking window
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bus.AN <= 8'hFF;
            bus.SEG <= SEG_BLANK;
            bus.DP <= 1'b1;
        end else begin
            bus.AN <= div_cnt < BLANK_END ? 8'hFF : ~(8'b1 << dig);
            bus.SEG <= seg_d;
            bus.DP <= dp_d;
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: randomized and directed scoreboard bench for two LZ variants
module tb_seven_seg_scanner;
    localparam int RD = 4;
    localparam int BC = 1;
    localparam int FRAME = 8 * RD;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg0;
        logic [6:0] seg1;
        logic dp;
    } exp_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic [15:0] td;
    logic [3:0] fl;
    logic [2:0] st;
    int total = 0;
    int bad = 0;
    int k = 0;
    exp_t q[$];
    logic [15:0] m_val;
    logic [3:0] m_fl;
    logic [2:0] m_st;
    logic [6:0] hex_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seven_seg_scanner_if bus0 ();
    seven_seg_scanner_if bus1 ();
    assign bus0.ToDisplay = td;
    assign bus0.Flags = fl;
    assign bus0.Status = st;
    assign bus1.ToDisplay = td;
    assign bus1.Flags = fl;
    assign bus1.Status = st;

    seven_seg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(0)) dut0 (
        .clk(clk), .resetN(resetN), .bus(bus0.slave)
    );
    seven_seg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(1)) dut1 (
        .clk(clk), .resetN(resetN), .bus(bus1.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_for(input int ts, input logic [15:0] v, input logic [2:0] s, input bit lz);
        int d;
        logic [15:0] upper;
        d = (ts / RD) % 8;
        upper = v >> (4 * d);
        if (d == 7) return hex_ref[s];
        if (d >= 4) return 7'h7F;
        if (lz && d > 0 && upper == 16'h0) return 7'h7F;
        return hex_ref[upper[3:0]];
    endfunction

    // reference model: time since release -> digit and slot phase; snapshot refreshed every FRAME edges
    initial forever begin
        @(posedge clk);
        if (!resetN) begin
            k = 0;
            m_val = '0;
            m_fl = '0;
            m_st = '0;
            q.delete();
        end else begin
            exp_t e;
            int d;
            d = (k / RD) % 8;
            e.an = (k % RD) < BC ? 8'hFF : ~(8'(1) << d);
            e.seg0 = seg_for(k, m_val, m_st, 1'b0);
            e.seg1 = seg_for(k, m_val, m_st, 1'b1);
            e.dp = d >= 4 ? ~m_fl[d - 4] : 1'b1;
            q.push_back(e);
            k++;
            if (k % FRAME == 0) begin
                m_val = td;
                m_fl = fl;
                m_st = st;
            end
        end
    end

    // monitor: reset values while in reset, otherwise pop and compare each presented output
    initial forever begin
        @(negedge clk);
        if (!resetN) begin
            chk("rst_an", {8'h0, bus0.AN}, 16'h00FF);
            chk("rst_seg", {9'h0, bus0.SEG}, 16'h007F);
            chk("rst_dp", {15'h0, bus0.DP}, 16'h0001);
            chk("rst_an_lz", {8'h0, bus1.AN}, 16'h00FF);
        end else if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("an", {8'h0, bus0.AN}, {8'h0, e.an});
            chk("seg", {9'h0, bus0.SEG}, {9'h0, e.seg0});
            chk("dp", {15'h0, bus0.DP}, {15'h0, e.dp});
            chk("an_lz", {8'h0, bus1.AN}, {8'h0, e.an});
            chk("seg_lz", {9'h0, bus1.SEG}, {9'h0, e.seg1});
            chk("dp_lz", {15'h0, bus1.DP}, {15'h0, e.dp});
        end
    end

    task automatic randomize_inputs();
        td = 16'($urandom);
        fl = 4'($urandom);
        st = 3'($urandom);
    endtask

    // wait until the next rising edge is at frame phase ph (0 = the 7->0 wrap edge)
    task automatic wait_phase(input int ph);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if ((k + 1) % FRAME == ph) return;
        end
        total++;
        bad++;
        $display("FAIL wait_phase timeout ph=%0d", ph);
    endtask

    initial begin
        randomize_inputs();
        resetN = 1'b0;
        repeat (5) begin
            @(negedge clk);
            randomize_inputs();
        end
        resetN = 1'b1;
        repeat (400) begin
            @(negedge clk);
            randomize_inputs();
        end
        td = 16'h1A8F; fl = 4'h0; st = 3'd0;
        repeat (2 * FRAME + 4) @(negedge clk);
        fl = 4'b1010; st = 3'd3;
        repeat (FRAME + 8) @(negedge clk);
        td = 16'h1234;
        repeat (FRAME + 8) @(negedge clk);
        wait_phase(2 * RD + 2);
        td = 16'hFFFF;
        repeat (2 * FRAME) @(negedge clk);
        td = 16'h0040;
        repeat (2 * FRAME + 4) @(negedge clk);
        td = 16'h0000;
        repeat (2 * FRAME + 4) @(negedge clk);
        wait_phase(0);
        td = 16'hBEEF; fl = 4'h5; st = 3'd6;
        repeat (FRAME / 2) @(negedge clk);
        wait_phase(1);
        td = 16'h0C0D; fl = 4'hC; st = 3'd2;
        repeat (2 * FRAME + 4) @(negedge clk);
        wait_phase(3);
        #2 resetN = 1'b0;
        #1;
        chk("async_an", {8'h0, bus0.AN}, 16'h00FF);
        chk("async_seg", {9'h0, bus0.SEG}, 16'h007F);
        chk("async_dp", {15'h0, bus0.DP}, 16'h0001);
        chk("async_seg_lz", {9'h0, bus1.SEG}, 16'h007F);
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        repeat (200) begin
            @(negedge clk);
            randomize_inputs();
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
